// File: rtl/iter_shift_unit_if.sv
// Request/response bundle between the control sequencer and iter_shift_unit.
// The carry_out wire exists only when SHIFT_CARRY_EN is defined.
interface iter_shift_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef SHIFT_CARRY_EN
    logic             carry_out;

    modport master (output start, op, operand, amount,
                    input  busy, done, result, carry_out);
    modport slave  (input  start, op, operand, amount,
                    output busy, done, result, carry_out);
`else
    modport master (output start, op, operand, amount,
                    input  busy, done, result);
    modport slave  (input  start, op, operand, amount,
                    output busy, done, result);
`endif
endinterface

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: SHR, SHRA, SHL, ROR, ROL, STEP bits per RUN cycle.
// Optional feature macro: SHIFT_CARRY_EN adds carry_out (last bit shifted out).
module iter_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic          clock,
    input  logic          clear,
    iter_shift_unit_if.slave bus
);
    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;
    localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0]    STEP_C  = CW'(STEP);
    localparam logic [WIDTH-1:0] WIDTH_W = WIDTH'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] work, work_sh, result_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    remaining, k, n_eff;
    logic             accept, last;
`ifdef SHIFT_CARRY_EN
    logic             carry_q, carry_sh;
`endif

    // Shift v by kk (1..WIDTH) according to op; unknown ops pass through.
    function automatic logic [WIDTH-1:0] shift_val(input logic [WIDTH-1:0] v,
                                                   input logic [2:0] o,
                                                   input logic [CW-1:0] kk);
        logic [WIDTH-1:0] r;
        case (o)
            3'd0:    r = v >> kk;
            3'd1:    r = $unsigned($signed(v) >>> kk);
            3'd2:    r = v << kk;
            3'd3:    r = (v >> kk) | (v << (WIDTH_C - kk));
            3'd4:    r = (v << kk) | (v >> (WIDTH_C - kk));
            default: r = v;
        endcase
        return r;
    endfunction

`ifdef SHIFT_CARRY_EN
    // Last bit to leave the word when shifting v by kk (kk >= 1).
    function automatic logic carry_bit(input logic [WIDTH-1:0] v,
                                       input logic [2:0] o,
                                       input logic [CW-1:0] kk);
        logic [LW-1:0] ri, li;
        logic          c;
        ri = LW'(kk - CW'(1));
        li = LW'(WIDTH_C - kk);
        case (o)
            3'd0, 3'd1, 3'd3: c = v[ri];
            3'd2, 3'd4:       c = v[li];
            default:          c = 1'b0;
        endcase
        return c;
    endfunction
`endif

    // Effective count: rotates wrap, shifts saturate at WIDTH, pass-through is zero.
    always_comb begin
        n_eff = '0;
        case (bus.op)
            3'd0, 3'd1, 3'd2: n_eff = (bus.amount >= WIDTH_W) ? WIDTH_C : bus.amount[CW-1:0];
            3'd3, 3'd4:       n_eff = {1'b0, bus.amount[LW-1:0]};
            default:          n_eff = '0;
        endcase
    end

    // Per-cycle step size and the shifted working value for this RUN cycle.
    always_comb begin
        k       = (remaining < STEP_C) ? remaining : STEP_C;
        last    = (remaining <= STEP_C);
        accept  = bus.start && (state != RUN);
        work_sh = shift_val(work, op_q, k);
`ifdef SHIFT_CARRY_EN
        carry_sh = carry_bit(work, op_q, k);
`endif
    end

    // State register.
    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic; start during RUN is simply not looked at.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) state_n = (n_eff != '0) ? RUN : DONE;
                else           state_n = IDLE;
            end
            RUN:     if (last) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: capture at acceptance, shift in RUN, publish result on entry to DONE.
    always_ff @(posedge clock) begin
        if (clear) begin
            work      <= '0;
            op_q      <= '0;
            remaining <= '0;
            result_q  <= '0;
`ifdef SHIFT_CARRY_EN
            carry_q   <= 1'b0;
`endif
        end else if (accept) begin
            work      <= bus.operand;
            op_q      <= bus.op;
            remaining <= n_eff;
            if (n_eff == '0) begin
                result_q <= bus.operand;
`ifdef SHIFT_CARRY_EN
                carry_q  <= 1'b0;
`endif
            end
        end else if (state == RUN) begin
            work      <= work_sh;
            remaining <= remaining - k;
            if (last) begin
                result_q <= work_sh;
`ifdef SHIFT_CARRY_EN
                carry_q  <= carry_sh;
`endif
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
`ifdef SHIFT_CARRY_EN
    assign bus.carry_out = carry_q;
`endif
endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: a STEP=1 and a STEP=4 instance fed the same requests,
// checked against a bit-level reference model of the shift/rotate rules.
module tb_iter_shift_unit;
    localparam int W = 32;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    iter_shift_unit_if #(.WIDTH(W)) sif ();
    iter_shift_unit_if #(.WIDTH(W)) sif4 ();

    assign sif4.start   = sif.start;
    assign sif4.op      = sif.op;
    assign sif4.operand = sif.operand;
    assign sif4.amount  = sif.amount;

    iter_shift_unit #(.WIDTH(W), .STEP(1)) dut1 (.clock(clock), .clear(clear), .bus(sif));
    iter_shift_unit #(.WIDTH(W), .STEP(4)) dut4 (.clock(clock), .clear(clear), .bus(sif4));

    always #5 clock = ~clock;

    // Reference: effective count, result and last bit out, from the operation definitions.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] amt, output logic [W-1:0] res,
                                  output logic c, output int n);
        if (o == 3 || o == 4)  n = int'(amt % W);
        else if (o <= 2)       n = (amt > W) ? W : int'(amt);
        else                   n = 0;
        res = a;
        c   = 1'b0;
        if (n > 0) begin
            case (o)
                0: begin res = a >> n; c = a[n-1]; end
                1: begin
                    for (int i = 0; i < W; i++) res[i] = (i + n < W) ? a[i+n] : a[W-1];
                    c = a[n-1];
                end
                2: begin res = a << n; c = a[W-n]; end
                3: begin
                    for (int i = 0; i < W; i++) res[i] = a[(i+n)%W];
                    c = a[n-1];
                end
                4: begin
                    for (int i = 0; i < W; i++) res[(i+n)%W] = a[i];
                    c = a[W-n];
                end
                default: ;
            endcase
        end
    endfunction

    task automatic test_reset();
        clear = 1'b1;
        sif.start = 1'b0; sif.op = '0; sif.operand = '0; sif.amount = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total_cnt++; if (sif.busy !== 1'b0) $display("FAIL reset_busy1 got %b want 0", sif.busy); else pass_cnt++;
        total_cnt++; if (sif.done !== 1'b0) $display("FAIL reset_done1 got %b want 0", sif.done); else pass_cnt++;
        total_cnt++; if (sif.result !== '0) $display("FAIL reset_result1 got %h want 0", sif.result); else pass_cnt++;
        total_cnt++; if (sif4.busy !== 1'b0) $display("FAIL reset_busy4 got %b want 0", sif4.busy); else pass_cnt++;
        total_cnt++; if (sif4.done !== 1'b0) $display("FAIL reset_done4 got %b want 0", sif4.done); else pass_cnt++;
        total_cnt++; if (sif4.result !== '0) $display("FAIL reset_result4 got %h want 0", sif4.result); else pass_cnt++;
`ifdef SHIFT_CARRY_EN
        total_cnt++; if (sif.carry_out !== 1'b0) $display("FAIL reset_carry got %b want 0", sif.carry_out); else pass_cnt++;
`endif
        clear = 1'b0;
    endtask

    // One request to both units; checks latency, busy length, result, carry, done width.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] amt,
                         input string nm);
        logic [W-1:0] er, r1, r4;
        logic ec, c1, c4;
        int n, e1, e4, b1, b4;
        model(o, a, amt, er, ec, n);
        e1 = -1; e4 = -1; b1 = 0; b4 = 0; r1 = '0; r4 = '0; c1 = 1'b0; c4 = 1'b0;
        @(negedge clock);
        sif.start = 1'b1; sif.op = o; sif.operand = a; sif.amount = amt;
        for (int e = 1; e <= 80 && (e1 < 0 || e4 < 0); e++) begin
            @(posedge clock);
            if (e == 1) begin #1 sif.start = 1'b0; sif.operand = ~a; sif.amount = amt + 7; end
            @(negedge clock);
            if (sif.busy) b1++;
            if (sif4.busy) b4++;
            if (sif.done && e1 < 0) begin
                e1 = e; r1 = sif.result;
`ifdef SHIFT_CARRY_EN
                c1 = sif.carry_out;
`endif
            end
            if (sif4.done && e4 < 0) begin
                e4 = e; r4 = sif4.result;
`ifdef SHIFT_CARRY_EN
                c4 = sif4.carry_out;
`endif
            end
        end
        total_cnt++; if (e1 != n + 1) $display("FAIL %s lat1 got %0d want %0d", nm, e1, n + 1); else pass_cnt++;
        total_cnt++; if (e4 != (n + 3) / 4 + 1) $display("FAIL %s lat4 got %0d want %0d", nm, e4, (n + 3) / 4 + 1); else pass_cnt++;
        total_cnt++; if (r1 !== er) $display("FAIL %s result1 got %h want %h", nm, r1, er); else pass_cnt++;
        total_cnt++; if (r4 !== er) $display("FAIL %s result4 got %h want %h", nm, r4, er); else pass_cnt++;
        total_cnt++; if (b1 != n) $display("FAIL %s busy1 got %0d want %0d", nm, b1, n); else pass_cnt++;
        total_cnt++; if (b4 != (n + 3) / 4) $display("FAIL %s busy4 got %0d want %0d", nm, b4, (n + 3) / 4); else pass_cnt++;
`ifdef SHIFT_CARRY_EN
        total_cnt++; if (c1 !== ec) $display("FAIL %s carry1 got %b want %b", nm, c1, ec); else pass_cnt++;
        total_cnt++; if (c4 !== ec) $display("FAIL %s carry4 got %b want %b", nm, c4, ec); else pass_cnt++;
`endif
        @(posedge clock);
        @(negedge clock);
        total_cnt++; if (sif.done !== 1'b0 || sif4.done !== 1'b0)
            $display("FAIL %s done_pulse got %b/%b want 0/0", nm, sif.done, sif4.done); else pass_cnt++;
        total_cnt++; if (sif.result !== er) $display("FAIL %s result_hold got %h want %h", nm, sif.result, er); else pass_cnt++;
    endtask

    task automatic test_directed();
        do_op(3'd4, 32'h0000007F, 32'd1,  "rol_7f_1");
        do_op(3'd3, 32'h00000001, 32'd4,  "ror_1_4");
        do_op(3'd1, 32'h80000000, 32'd40, "shra_sat");
        do_op(3'd2, 32'h12345678, 32'd40, "shl_sat");
        do_op(3'd4, 32'hA5C3_0F1E, 32'd32, "rol_mod0");
        do_op(3'd6, 32'hA5C3_0F1E, 32'd5,  "pass_op6");
        do_op(3'd0, 32'hFFFF_FFFF, 32'd31, "shr_31");
        do_op(3'd1, 32'h4000_0000, 32'd32, "shra_pos_all");
    endtask

    task automatic test_random();
        logic [W-1:0] amt;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       amt = $urandom_range(0, 33);
                1:       amt = $urandom_range(0, 8);
                2:       amt = $urandom;
                default: amt = $urandom_range(28, 40);
            endcase
            do_op(3'($urandom_range(0, 7)), $urandom, amt, "rand");
        end
    endtask

    // Start during RUN is ignored; then clear aborts an op with no done.
    task automatic test_ignore_and_clear();
        int e1;
        bit saw;
        @(negedge clock);
        sif.start = 1'b1; sif.op = 3'd2; sif.operand = 32'h1; sif.amount = 32'd8;
        @(posedge clock); #1 sif.start = 1'b0;
        @(posedge clock); #1 sif.start = 1'b1; sif.op = 3'd4; sif.operand = 32'hFFFF0000; sif.amount = 32'd3;
        @(posedge clock); #1 sif.start = 1'b0;
        e1 = -1;
        for (int e = 4; e <= 40 && e1 < 0; e++) begin
            @(negedge clock);
            if (sif.done) e1 = e - 1;
            else @(posedge clock);
        end
        total_cnt++; if (e1 != 9) $display("FAIL ignore_lat got %0d want 9", e1); else pass_cnt++;
        total_cnt++; if (sif.result !== 32'h100) $display("FAIL ignore_result got %h want 00000100", sif.result); else pass_cnt++;
        repeat (2) @(posedge clock);
        @(negedge clock);
        sif.start = 1'b1; sif.op = 3'd2; sif.operand = 32'h1; sif.amount = 32'd8;
        @(posedge clock); #1 sif.start = 1'b0;
        repeat (3) @(posedge clock);
        #1 clear = 1'b1;
        @(posedge clock); #1 clear = 1'b0;
        @(negedge clock);
        total_cnt++; if (sif.busy !== 1'b0) $display("FAIL clear_busy got %b want 0", sif.busy); else pass_cnt++;
        total_cnt++; if (sif.result !== '0) $display("FAIL clear_result got %h want 0", sif.result); else pass_cnt++;
        total_cnt++; if (sif4.result !== '0) $display("FAIL clear_result4 got %h want 0", sif4.result); else pass_cnt++;
        saw = 1'b0;
        for (int e = 0; e < 15; e++) begin
            if (sif.done || sif4.done || sif.busy) saw = 1'b1;
            @(negedge clock);
        end
        total_cnt++; if (saw) $display("FAIL clear_no_done got activity want none"); else pass_cnt++;
    endtask

    // Start in the DONE cycle goes straight to RUN.
    task automatic test_back_to_back();
        logic [W-1:0] er1, er2, a2;
        logic ec;
        int n1, n2, e2;
        bit got;
        a2 = $urandom;
        model(3'd4, 32'h0F000001, 32'd3, er1, ec, n1);
        model(3'd0, a2, 32'd5, er2, ec, n2);
        @(negedge clock);
        sif.start = 1'b1; sif.op = 3'd4; sif.operand = 32'h0F000001; sif.amount = 32'd3;
        @(posedge clock); #1 sif.start = 1'b0;
        got = 1'b0;
        for (int e = 0; e < 40 && !got; e++) begin
            @(negedge clock);
            if (sif.done) got = 1'b1;
        end
        total_cnt++; if (!got || sif.result !== er1) $display("FAIL b2b_first got %h want %h", sif.result, er1); else pass_cnt++;
        sif.start = 1'b1; sif.op = 3'd0; sif.operand = a2; sif.amount = 32'd5;
        @(posedge clock); #1 sif.start = 1'b0;
        @(negedge clock);
        total_cnt++; if (sif.busy !== 1'b1) $display("FAIL b2b_no_idle busy got %b want 1", sif.busy); else pass_cnt++;
        e2 = -1;
        for (int e = 1; e <= 40 && e2 < 0; e++) begin
            if (sif.done) e2 = e;
            else begin @(posedge clock); @(negedge clock); end
        end
        total_cnt++; if (e2 != n2 + 1) $display("FAIL b2b_lat got %0d want %0d", e2, n2 + 1); else pass_cnt++;
        total_cnt++; if (sif.result !== er2) $display("FAIL b2b_result got %h want %h", sif.result, er2); else pass_cnt++;
        repeat (3) @(posedge clock);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_and_clear();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
